// File: rtl/player_cmd_receiver.sv
// Player command receiver: 8N1 UART byte receiver feeding a command decoder
// that tracks the player lane and projectile type and emits one-cycle
// fire/valid/error pulses.
module player_cmd_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] lane,
  output logic       proj_type,
  output logic       fire_pulse,
  output logic       cmd_valid,
  output logic       frame_error,
  output logic       cmd_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Sample instants expressed as terminal counts of a counter that starts at 0.
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LANE_HOME = 4'd5;
  localparam logic [3:0]  LANE_MAX  = 4'd9;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic        rx_prev_q, rx_prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  lane_q, lane_d;
  logic        proj_q, proj_d;
  logic        fire_q, fire_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        cerr_q, cerr_d;

  logic        start_edge;
  logic        stop_sample;
  logic [3:0]  code;
  logic        bad_cmd;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;

  // Receiver FSM: next state, baud counter, bit index and shift register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (start_edge) begin
          state_d = START;
          bit_d   = 3'd0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = 16'd0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = 16'd0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d       = 16'd0;
          stop_sample = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign code    = shift_q[3:0];
  assign bad_cmd = (shift_q[7:6] != 2'b00) || (code > LANE_MAX);

  // Command decode at the stop sample; results land one cycle later.
  always_comb begin
    lane_d  = lane_q;
    proj_d  = proj_q;
    fire_d  = 1'b0;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    cerr_d  = 1'b0;
    if (stop_sample) begin
      if (!rx_sync_q) begin
        ferr_d = 1'b1;
      end else if (bad_cmd) begin
        cerr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        fire_d  = shift_q[4];
        proj_d  = shift_q[5];
        lane_d  = (code == 4'd0) ? LANE_HOME : code;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      lane_q    <= LANE_HOME;
      proj_q    <= 1'b0;
      fire_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      lane_q    <= lane_d;
      proj_q    <= proj_d;
      fire_q    <= fire_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      cerr_q    <= cerr_d;
    end
  end

  assign lane        = lane_q;
  assign proj_type   = proj_q;
  assign fire_pulse  = fire_q;
  assign cmd_valid   = valid_q;
  assign frame_error = ferr_q;
  assign cmd_error   = cerr_q;

endmodule

// File: tb/tb_player_cmd_receiver.sv
// Bench for player_cmd_receiver: directed scenarios followed by random
// frames, checked against a byte-level command model.
module tb_player_cmd_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [3:0] lane;
  logic       proj_type;
  logic       fire_pulse;
  logic       cmd_valid;
  logic       frame_error;
  logic       cmd_error;

  player_cmd_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .lane        (lane),
    .proj_type   (proj_type),
    .fire_pulse  (fire_pulse),
    .cmd_valid   (cmd_valid),
    .frame_error (frame_error),
    .cmd_error   (cmd_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed pulse statistics.
  int n_valid = 0, n_fire = 0, n_ferr = 0, n_cerr = 0;
  int n_orphan = 0, n_long = 0, n_excl = 0, n_spur = 0;
  logic       prev_fire = 1'b0;
  logic       prev_rst  = 1'b0;
  logic [3:0] prev_lane = 4'd5;
  logic       prev_proj = 1'b0;

  // Expected values from the command model.
  int         e_valid = 0, e_fire = 0, e_ferr = 0, e_cerr = 0;
  logic [3:0] m_lane = 4'd5;
  logic       m_proj = 1'b0;

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (cmd_valid)   n_valid <= n_valid + 1;
    if (fire_pulse)  n_fire  <= n_fire + 1;
    if (frame_error) n_ferr  <= n_ferr + 1;
    if (cmd_error)   n_cerr  <= n_cerr + 1;
    if (fire_pulse && !cmd_valid) n_orphan <= n_orphan + 1;
    if (fire_pulse && prev_fire)  n_long   <= n_long + 1;
    if ((cmd_valid && frame_error) || (cmd_valid && cmd_error) || (frame_error && cmd_error))
      n_excl <= n_excl + 1;
    if (rst && prev_rst && !cmd_valid && ((lane !== prev_lane) || (proj_type !== prev_proj)))
      n_spur <= n_spur + 1;
    prev_fire <= fire_pulse;
    prev_rst  <= rst;
    prev_lane <= lane;
    prev_proj <= proj_type;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_cnt"}, n_valid, e_valid);
    chk({tag, ".fire_cnt"},  n_fire,  e_fire);
    chk({tag, ".ferr_cnt"},  n_ferr,  e_ferr);
    chk({tag, ".cerr_cnt"},  n_cerr,  e_cerr);
    chk({tag, ".lane"},      {28'd0, lane}, {28'd0, m_lane});
    chk({tag, ".proj"},      {31'd0, proj_type}, {31'd0, m_proj});
  endtask

  // Command rules applied to a whole received frame.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    int code;
    code = int'(b[3:0]);
    if (!stop_ok) e_ferr++;
    else if (b[7:6] != 2'b00 || code > 9) e_cerr++;
    else begin
      e_valid++;
      if (b[4]) e_fire++;
      m_proj = b[5];
      m_lane = (code == 0) ? 4'd5 : b[3:0];
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input string tag);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
    rx = stop_ok;
    bit_time();
    if (!stop_ok) idle(4);
    model_frame(b, stop_ok);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_lane = 4'd5;
    m_proj = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;

    // Reset state.
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.lane",  {28'd0, lane}, 32'd5);
    chk("reset.proj",  {31'd0, proj_type}, 32'd0);
    chk("reset.fire",  {31'd0, fire_pulse}, 32'd0);
    chk("reset.valid", {31'd0, cmd_valid}, 32'd0);
    chk("reset.ferr",  {31'd0, frame_error}, 32'd0);
    chk("reset.cerr",  {31'd0, cmd_error}, 32'd0);
    rst = 1'b1;
    idle(5);

    // Fire with lane 3.
    send(8'h13, 1'b1, "fire13");

    // Back-to-back: lane reset code with projectile 1, then lane 9.
    send(8'h20, 1'b1, "b2b_20");
    send(8'h09, 1'b1, "b2b_09");

    // Illegal lane code, then reserved bits set.
    do_reset();
    idle(5);
    send(8'h0A, 1'b1, "err_0A");
    send(8'h45, 1'b1, "err_45");

    // Broken stop bit, then the same byte framed correctly.
    send(8'h07, 1'b0, "ferr_07");
    send(8'h07, 1'b1, "good_07");

    // Short low glitch on the idle line.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(20);
    check_all("glitch");
    send(8'h01, 1'b1, "post_glitch");

    // Reset in the middle of bit 4 of 0x18; the sender abandons the frame.
    b = 8'h18;
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      bit_time();
    end
    rx = b[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    do_reset();
    idle(20);
    check_all("mid_reset");
    send(8'h12, 1'b1, "post_reset");

    // Random frames with occasional broken stop bits and random gaps.
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send(b, ok, $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
    end

    idle(4);
    chk("fire_without_valid", n_orphan, 32'd0);
    chk("fire_longer_than_1", n_long,   32'd0);
    chk("pulse_overlap",      n_excl,   32'd0);
    chk("lane_change_no_vld", n_spur,   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
